// File: rtl/sample_fifo_pkg.sv
// Register map and STATUS bit layout for the sampling FIFO slot core.
package sample_fifo_pkg;

  localparam logic [4:0] REG_STATUS = 5'd0;
  localparam logic [4:0] REG_DATA   = 5'd1;
  localparam logic [4:0] REG_POP    = 5'd2;
  localparam logic [4:0] REG_CTRL   = 5'd3;
  localparam logic [4:0] REG_DIV    = 5'd4;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_OVERFLOW  = 16;
  localparam int ST_ENABLE    = 17;

endpackage

// File: rtl/sample_fifo_buf.sv
// Register-file FIFO with flush. A push is accepted while full only when a pop
// happens in the same cycle.
module sample_fifo_buf #(
  parameter int W      = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              flush,
  input  logic [W-1:0]      push_data,
  output logic [W-1:0]      head,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_en & (~full | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_fifo_core.sv
// Fpro-bus slot that samples a synchronized input every DIV clocks into a FIFO
// drained by firmware; a sticky flag records samples dropped while full.
module sample_fifo_core
  import sample_fifo_pkg::*;
#(
  parameter int W      = 16,
  parameter int ADDR_W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  input  logic [W-1:0] din
);

  logic [W-1:0]    din_s1;
  logic [W-1:0]    din_s2;
  logic            enable;
  logic            overflow;
  logic [31:0]     div_q;
  logic [31:0]     div_max;
  logic [31:0]     presc_cnt;
  logic            tick;
  logic            ctrl_wr;
  logic            div_wr;
  logic            pop_wr;
  logic            flush;
  logic [W-1:0]    head;
  logic [ADDR_W:0] count;
  logic            empty;
  logic            full;
  logic            unused_read;

  // rd_data is a pure address mux, so the read strobe carries no information.
  assign unused_read = read;

  assign ctrl_wr = cs & write & (addr == REG_CTRL);
  assign div_wr  = cs & write & (addr == REG_DIV);
  assign pop_wr  = cs & write & (addr == REG_POP);
  assign flush   = ctrl_wr & wr_data[1];
  assign div_max = (div_q == 32'd0) ? 32'd0 : div_q - 32'd1;
  assign tick    = enable & (presc_cnt == div_max);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_s1    <= '0;
      din_s2    <= '0;
      enable    <= 1'b0;
      div_q     <= '0;
      presc_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      din_s1 <= din;
      din_s2 <= din_s1;
      if (ctrl_wr) enable <= wr_data[0];
      if (div_wr)  div_q  <= wr_data;
      if (div_wr || !enable || tick) presc_cnt <= '0;
      else                           presc_cnt <= presc_cnt + 32'd1;
      // A pop in the tick cycle frees a slot, so only an unpaired tick overflows.
      if (flush)                        overflow <= 1'b0;
      else if (tick && full && !pop_wr) overflow <= 1'b1;
    end
  end

  sample_fifo_buf #(.W(W), .ADDR_W(ADDR_W)) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (tick),
    .rd_en     (pop_wr),
    .flush     (flush),
    .push_data (din_s2),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always_comb begin
    rd_data = '0;
    case (addr)
      REG_STATUS: begin
        rd_data[ST_EMPTY]                    = empty;
        rd_data[ST_FULL]                     = full;
        rd_data[ST_COUNT_LSB +: ADDR_W+1]    = count;
        rd_data[ST_OVERFLOW]                 = overflow;
        rd_data[ST_ENABLE]                   = enable;
      end
      REG_DATA: if (!empty) rd_data[W-1:0] = head;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_sample_fifo_core.sv
// Directed bench: each bus read pushes its hand-computed expectation onto a
// queue that a negedge monitor pops and compares against rd_data.
module tb_sample_fifo_core;
  import sample_fifo_pkg::*;

  localparam int W = 16;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cs;
  logic         read;
  logic         write;
  logic [4:0]   addr;
  logic [31:0]  wr_data;
  logic [31:0]  rd_data;
  logic [W-1:0] din;
  logic [W-1:0] din_fixed;
  logic         din_mode;
  int unsigned  cyc = 0;
  int unsigned  e;
  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  sample_fifo_core #(.W(W), .ADDR_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .din     (din)
  );

  always #5 clk = ~clk;

  // Edge index: in the cycle after posedge n, cyc == n, so in counting mode the
  // sample written at edge k is k-3 (two sync flops plus the push edge).
  always @(posedge clk) cyc <= cyc + 1;
  assign din = din_mode ? cyc[W-1:0] : din_fixed;

  always @(negedge clk) begin
    if (cs && read) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL unexpected_read addr=%0d rd_data=%h required=no read", addr, rd_data);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        if (rd_data !== x.value) begin
          n_bad++;
          $display("[TB] FAIL %s addr=%0d rd_data=%h required=%h", x.name, addr, rd_data, x.value);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Both tasks start one time unit after a posedge and return at the same
  // phase one cycle later; a write takes effect on the intervening edge.
  task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] a, input logic [31:0] v);
    exp_t x;
    x.name  = name;
    x.value = v;
    exp_q.push_back(x);
    cs = 1'b1; read = 1'b1; addr = a;
    @(posedge clk); #1;
    cs = 1'b0; read = 1'b0; addr = '0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0; din_fixed = 16'h00A5; din_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    $display("[TB] reset state");
    checkOutput("reset_status", REG_STATUS, 32'h0000_0001);
    checkOutput("reset_data",   REG_DATA,   32'h0000_0000);
    checkOutput("unmapped_5",   5'd5,       32'h0000_0000);
    checkOutput("unmapped_15",  5'd15,      32'h0000_0000);
    checkOutput("unmapped_31",  5'd31,      32'h0000_0000);

    $display("[TB] periodic capture DIV=10");
    applyStimulus(REG_DIV, 32'd10);
    applyStimulus(REG_CTRL, 32'h1);
    waitCycles(9);
    checkOutput("div10_before_first", REG_STATUS, 32'h0002_0001);
    checkOutput("div10_first_tick",   REG_STATUS, 32'h0002_0100);
    waitCycles(19);
    checkOutput("div10_three",        REG_STATUS, 32'h0002_0300);
    checkOutput("div10_data",         REG_DATA,   32'h0000_00A5);
    applyStimulus(REG_POP, 32'h0);
    checkOutput("div10_after_pop",    REG_STATUS, 32'h0002_0200);
    applyStimulus(REG_CTRL, 32'h2);
    checkOutput("div10_flushed",      REG_STATUS, 32'h0000_0001);

    $display("[TB] overflow DIV=1");
    din_mode = 1'b1;
    applyStimulus(REG_DIV, 32'd1);
    applyStimulus(REG_CTRL, 32'h1);
    e = cyc;
    waitCycles(19);
    applyStimulus(REG_CTRL, 32'h0);
    checkOutput("ovf_status", REG_STATUS, 32'h0001_1002);
    for (int i = 0; i < 16; i++) begin
      checkOutput("ovf_order", REG_DATA, (e - 32'd2 + 32'(i)) & 32'h0000_FFFF);
      applyStimulus(REG_POP, 32'h0);
    end
    checkOutput("ovf_drained", REG_STATUS, 32'h0001_0001);
    applyStimulus(REG_CTRL, 32'h2);
    checkOutput("ovf_flushed", REG_STATUS, 32'h0000_0001);

    $display("[TB] full + pop + tick");
    applyStimulus(REG_CTRL, 32'h1);
    e = cyc;
    waitCycles(15);
    checkOutput("fpt_fifteen", REG_STATUS, 32'h0002_0F00);
    applyStimulus(REG_POP, 32'h0);
    checkOutput("fpt_status",  REG_STATUS, 32'h0002_1002);
    checkOutput("fpt_head",    REG_DATA,   (e - 32'd1) & 32'h0000_FFFF);
    applyStimulus(REG_CTRL, 32'h0);

    $display("[TB] flush vs tick");
    applyStimulus(REG_CTRL, 32'h1);
    applyStimulus(REG_CTRL, 32'h3);
    checkOutput("flush_tick",      REG_STATUS, 32'h0002_0001);
    checkOutput("flush_next_tick", REG_STATUS, 32'h0002_0100);
    waitCycles(4);
    applyStimulus(REG_CTRL, 32'h0);
    checkOutput("seven_held", REG_STATUS, 32'h0000_0700);

    $display("[TB] async reset mid-stream");
    #3 reset_n = 1'b0;
    checkOutput("async_reset_now", REG_STATUS, 32'h0000_0001);
    reset_n = 1'b1;
    waitCycles(20);
    checkOutput("post_reset_idle", REG_STATUS, 32'h0000_0001);
    checkOutput("post_reset_data", REG_DATA,   32'h0000_0000);
    applyStimulus(REG_CTRL, 32'h1);
    waitCycles(1);
    checkOutput("div0_as_1", REG_STATUS, 32'h0002_0100);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL leftover_expect pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
